// File: rtl/weight_fifo_out_seq.sv
// Weight FIFO read-out sequencer: drives per-column FIFO read enables in broadcast or
// skewed (diagonal wavefront) order, plus registered weight-register write enables.

module weight_fifo_out_seq_col #(
  parameter int COL     = 0,
  parameter int CNT_W   = 6,
  parameter int DEPTH_W = 5
) (
  input  logic [CNT_W-1:0]   cnt,
  input  logic [DEPTH_W-1:0] depth,
  input  logic               skew,
  input  logic               go,
  output logic               en
);
  logic [CNT_W-1:0] lo, hi;

  // Column window is [lo, lo+depth); broadcast collapses every column onto lo=0.
  assign lo = skew ? CNT_W'(COL) : '0;
  assign hi = lo + CNT_W'(depth);
  assign en = go && (cnt >= lo) && (cnt < hi);
endmodule

module weight_fifo_out_seq #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 16,
  localparam int DEPTH_W   = $clog2(FIFO_DEPTH) + 1,
  localparam int CNT_W     = $clog2(FIFO_DEPTH + FIFO_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [DEPTH_W-1:0]    cfg_depth,
  input  logic                  cfg_skew,
  input  logic                  stall,
  output logic                  busy,
  output logic                  done,
  output logic [FIFO_WIDTH-1:0] fifo_en,
  output logic [FIFO_WIDTH-1:0] w_wen
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx, last;
  logic [DEPTH_W-1:0] depth_q, depth_sat;
  logic               skew_q, accept, ld, go;

  assign accept    = start && (cfg_depth != '0) && ((state == IDLE) || (state == FLUSH));
  assign depth_sat = (cfg_depth > DEPTH_W'(FIFO_DEPTH)) ? DEPTH_W'(FIFO_DEPTH) : cfg_depth;
  // Skew stretches the run so the last column gets its full window.
  assign last      = skew_q ? CNT_W'(depth_q) + CNT_W'(FIFO_WIDTH - 2)
                            : CNT_W'(depth_q) - CNT_W'(1);
  assign go        = (state == RUN) && !stall;
  assign busy      = (state != IDLE);
  assign done      = (state == FLUSH);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ld       = 1'b0;
    case (state)
      IDLE: if (accept) begin
        state_nx = RUN;
        cnt_nx   = '0;
        ld       = 1'b1;
      end
      RUN: if (!stall) begin
        if (cnt == last) begin
          state_nx = FLUSH;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      FLUSH: begin
        state_nx = IDLE;
        if (accept) begin
          state_nx = RUN;
          cnt_nx   = '0;
          ld       = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= IDLE;
      cnt     <= '0;
      depth_q <= '0;
      skew_q  <= 1'b0;
      w_wen   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      w_wen <= fifo_en;
      if (ld) begin
        depth_q <= depth_sat;
        skew_q  <= cfg_skew;
      end
    end
  end

  for (genvar c = 0; c < FIFO_WIDTH; c++) begin : g_col
    weight_fifo_out_seq_col #(
      .COL(c), .CNT_W(CNT_W), .DEPTH_W(DEPTH_W)
    ) u_col (
      .cnt  (cnt),
      .depth(depth_q),
      .skew (skew_q),
      .go   (go),
      .en   (fifo_en[c])
    );
  end
endmodule

// File: tb/tb_weight_fifo_out_seq.sv
// Randomized + directed bench for weight_fifo_out_seq against a job-level reference model.

module tb_weight_fifo_out_seq;
  localparam int W = 4;
  localparam int D = 16;

  logic         clk, rstn, start, cfg_skew, stall;
  logic [4:0]   cfg_depth;
  logic         busy, done;
  logic [W-1:0] fifo_en, w_wen;

  weight_fifo_out_seq #(.FIFO_WIDTH(W), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rstn(rstn), .start(start), .cfg_depth(cfg_depth), .cfg_skew(cfg_skew),
    .stall(stall), .busy(busy), .done(done), .fifo_en(fifo_en), .w_wen(w_wen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  // Model: phase 0=idle, 1=running, 2=final beat; k = non-stalled run cycles so far.
  int           m_phase, m_k, m_d;
  bit           m_s;
  logic [W-1:0] m_wen;
  int           colcnt [W];
  int           n_done;
  logic [W-1:0] last_en;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] exp_en(bit sl);
    logic [W-1:0] r;
    r = '0;
    if (m_phase == 1 && !sl)
      for (int c = 0; c < W; c++) begin
        int lo;
        lo = m_s ? c : 0;
        r[c] = (m_k >= lo) && (m_k < lo + m_d);
      end
    return r;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_k = 0; m_d = 0; m_s = 0; m_wen = '0;
    for (int c = 0; c < W; c++) colcnt[c] = 0;
  endtask

  // Apply inputs for one cycle, check outputs, advance the model, move to next cycle.
  task automatic cycle(input bit st, input int d, input bit sk, input bit sl, input bit rst);
    logic [W-1:0] e;
    int           len;
    bit           can_take;
    start = st; cfg_depth = 5'(d); cfg_skew = sk; stall = sl; rstn = !rst;
    #1;
    e = exp_en(sl);
    chk("fifo_en", 32'(fifo_en), 32'(e));
    chk("w_wen", 32'(w_wen), 32'(m_wen));
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("done", 32'(done), 32'(m_phase == 2));
    last_en = fifo_en;
    n_done += int'(done);
    for (int c = 0; c < W; c++) colcnt[c] += int'(w_wen[c]);
    if (m_phase == 2)
      for (int c = 0; c < W; c++) chk("beats", 32'(colcnt[c]), 32'(m_d));
    if (rst) begin
      model_reset();
    end else begin
      m_wen    = e;
      can_take = (m_phase == 0) || (m_phase == 2);
      len      = m_s ? m_d + W - 1 : m_d;
      if (m_phase == 1) begin
        if (!sl) begin
          if (m_k == len - 1) begin m_phase = 2; m_k = 0; end
          else m_k++;
        end
      end else if (m_phase == 2) begin
        m_phase = 0;
      end
      if (st && (d % 32) != 0 && can_take) begin
        m_phase = 1; m_k = 0; m_d = ((d % 32) > D) ? D : (d % 32); m_s = sk;
        for (int c = 0; c < W; c++) colcnt[c] = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
  endtask

  logic [W-1:0] sk_tab [6];

  initial begin
    sk_tab = '{4'h1, 4'h3, 4'h7, 4'hE, 4'hC, 4'h8};
    n_done = 0;
    rstn = 0; start = 0; cfg_depth = '0; cfg_skew = 0; stall = 0;
    repeat (2) @(negedge clk);
    model_reset();
    idle(2);

    // Broadcast depth 8
    n_done = 0;
    cycle(1, 8, 0, 0, 0);
    idle(12);
    chk("bcast_done_cnt", 32'(n_done), 32'd1);

    // Skew depth 3: diagonal wavefront
    cycle(1, 3, 1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      cycle(0, 0, 0, 0, 0);
      chk("skew_wave", 32'(last_en), 32'(sk_tab[i]));
    end
    idle(4);

    // Broadcast depth 4 with stall in cycles 2-3
    n_done = 0;
    cycle(1, 4, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);
    idle(6);
    chk("stall_done_cnt", 32'(n_done), 32'd1);

    // Back-to-back: A depth 2, B (depth 5, skew) started in A's final cycle
    n_done = 0;
    cycle(1, 2, 0, 0, 0);
    idle(2);
    cycle(1, 5, 1, 0, 0);
    cycle(0, 0, 0, 0, 0);
    chk("b2b_first", 32'(last_en), 32'h1);
    idle(12);
    chk("b2b_done_cnt", 32'(n_done), 32'd2);

    // Ignored starts: depth 0, start during run, saturated depth
    n_done = 0;
    cycle(1, 0, 0, 0, 0);
    idle(3);
    chk("zero_depth_done", 32'(n_done), 32'd0);
    cycle(1, 6, 0, 0, 0);
    idle(2);
    cycle(1, 2, 1, 0, 0);
    idle(6);
    cycle(1, 31, 0, 0, 0);
    idle(20);
    chk("sat_done_cnt", 32'(n_done), 32'd2);

    // Reset mid-run at cnt=3, then a fresh job
    n_done = 0;
    cycle(1, 8, 0, 0, 0);
    idle(3);
    cycle(0, 0, 0, 0, 1);
    idle(12);
    chk("rst_no_done", 32'(n_done), 32'd0);
    cycle(1, 8, 0, 0, 0);
    idle(12);
    chk("rst_fresh_done", 32'(n_done), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom_range(0, 5) == 0), int'($urandom_range(0, 31)), 1'($urandom),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 149) == 0));
    end
    idle(40);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/weight_fifo_out_seq.md
Name: weight_fifo_out_seq

Overview:
Sequences the read-out of a FIFO_WIDTH-column weight FIFO bank into the PE array's weight registers. It drains a runtime-programmable number of rows (1..FIFO_DEPTH). Two modes are supported:
- Broadcast mode: all columns are enabled together.
- Skew mode: column c starts c cycles after column 0, giving a diagonal wavefront for systolic loading.

The block also supports stall, a registered write-enable that matches the FIFO's one-cycle read latency, and back-to-back jobs.

Parameters:
FIFO_WIDTH, 16, number of FIFO columns / PE columns driven
FIFO_DEPTH, 16, maximum rows per column; cfg_depth upper bound
DEPTH_W (localparam), $clog2(FIFO_DEPTH)+1, width of cfg_depth
CNT_W (localparam), $clog2(FIFO_DEPTH+FIFO_WIDTH)+1, width of the cycle counter

Ports:
clk  input  1  clock
rstn  input  1  synchronous active-low reset
start  input  1  job request pulse; sampled only in IDLE or FLUSH
cfg_depth  input  DEPTH_W  rows to drain; latched on start accept; legal 1..FIFO_DEPTH
cfg_skew  input  1  1 = skewed per-column timing, 0 = broadcast; latched on start accept
stall  input  1  downstream back-pressure; freezes sequencing
busy  output  1  high in RUN or FLUSH
done  output  1  one-cycle pulse, coincident with the final w_wen beat
fifo_en  output  FIFO_WIDTH  per-column FIFO read enable (combinational from state/counter)
w_wen  output  FIFO_WIDTH  per-column weight-register write enable; registered copy of fifo_en

Behaviour:
- Clock is clk. Reset is rstn, synchronous, active-low.
- Reset values: state=IDLE, cnt=0, latched depth=0, latched skew=0, w_wen=0. Consequently busy=0, done=0, fifo_en=0.
- Reset asserted mid-job aborts the job: all outputs are 0 on the next cycle and no done is issued.
- States:
  - IDLE: waits for start.
  - RUN: counter advances.
  - FLUSH: one cycle that emits the final w_wen beat.
- Start accept:
  - Condition: start=1 && cfg_depth!=0 && state in {IDLE, FLUSH}.
  - Action: latch cfg, set cnt=0, go to RUN.
  - start=1 with cfg_depth==0 is ignored: state unchanged, no done.
  - start in RUN is ignored.
  - Values of cfg_depth > FIFO_DEPTH are saturated to FIFO_DEPTH at latch.
- Run length L:
  - Broadcast: L = depth.
  - Skew: L = depth + FIFO_WIDTH - 1.
- fifo_en[c] in RUN with stall=0:
  - Broadcast: 1 for all c.
  - Skew: 1 iff c <= cnt < c + depth.
  - fifo_en is 0 in IDLE, in FLUSH, and whenever stall=1.
- Counter: in RUN, cnt increments by 1 each non-stalled cycle and holds while stalled.
  - A non-stalled RUN cycle with cnt == L-1 transitions to FLUSH and clears cnt.
- w_wen: registered each cycle as w_wen <= fifo_en. Each column therefore receives exactly depth w_wen beats per job, one cycle after its corresponding fifo_en beats.
- done:
  - Asserted for exactly one cycle, in FLUSH.
  - Stall has no effect in FLUSH: done and the final w_wen beat always complete.
- Back-to-back: a start accepted in FLUSH enters RUN on the next cycle with no idle gap; done for the previous job still pulses in that FLUSH cycle.
- Latency (no stall): start sampled at edge T gives the following timing:
  - First fifo_en at cycle T+1.
  - Last fifo_en at cycle T+L.
  - done and the last w_wen at cycle T+L+1.
  - busy is high from T+1 to T+L+1 inclusive.
- Stalls extend RUN by exactly the number of stalled RUN cycles.
- Invariant: per job, the popcount of fifo_en[c] over time equals depth for every c.

Test Plan:
- W=4, D=8, broadcast, cfg_depth=8, no stall, start at cycle 0 -> fifo_en=4'hF for cycles 1..8; w_wen=4'hF for cycles 2..9; done only at cycle 9; busy 1..9.
- W=4, skew, cfg_depth=3, start at cycle 0 -> L=6.
  - fifo_en by cycle, 1..6: 0001, 0011, 0111, 1110, 1100, 1000.
  - done at cycle 7; each column receives 3 w_wen beats.
- Broadcast, cfg_depth=4, stall high in cycles 2-3 -> fifo_en high in cycles 1, 4, 5, 6 and 0 in cycles 2-3; done at cycle 7; exactly 4 w_wen beats.
- Back-to-back: job A (depth=2, broadcast) with start re-asserted in A's FLUSH cycle, job B with depth=5 and skew=1 -> A's done pulses once; B's first fifo_en (0001) is on the next cycle; B's done arrives 9 cycles after its start.
- Illegal/ignored starts:
  - cfg_depth=0 -> no busy, no done.
  - start during RUN -> no effect on the count.
  - cfg_depth=31 with D=16 -> 16 beats.
- Reset mid-RUN: rstn=0 at cnt=3 -> next cycle fifo_en=0, w_wen=0, busy=0, and no done ever pulses; a fresh start then behaves as in the first scenario.
